// File: rtl/filter_pkg.sv
// filter_pkg: shared defaults and helpers for the filter_bank input conditioner.
//   FILTER_DEFAULT_CYCLES - default stability window in clocks
//   FILTER_DEFAULT_SYNC   - default synchroniser depth
//   filter_cnt_width()    - width of the per-channel stability counter
package filter_pkg;

    localparam int FILTER_DEFAULT_CYCLES = 8;
    localparam int FILTER_DEFAULT_SYNC   = 2;

    function automatic int filter_cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/filter_channel.sv
// filter_channel: one input conditioning lane.
//   synchroniser (SYNC_STAGES flops) -> stability counter -> edge detector
// Ports:
//   clk, reset (sync, active high)
//   din   - raw asynchronous input
//   out   - filtered level (straight from the state flop)
//   rise  - one-cycle pulse on the first cycle out shows 1
//   fall  - one-cycle pulse on the first cycle out shows 0
module filter_channel
    import filter_pkg::*;
#(
    parameter int   FILTER_CYCLES = FILTER_DEFAULT_CYCLES,
    parameter int   SYNC_STAGES   = FILTER_DEFAULT_SYNC,
    parameter logic INIT_VALUE    = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic out,
    output logic rise,
    output logic fall
);

    localparam int CW = filter_cnt_width(FILTER_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   state_q, state_d;
    logic                   prev_q, prev_d;
    logic                   sync;

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], din};
        sync    = sync_q[SYNC_STAGES-1];
        state_d = state_q;
        cnt_d   = '0;
        // Any agreeing sample drops cnt back to 0, so only an unbroken
        // run of FILTER_CYCLES disagreeing samples can flip the state.
        if (sync != state_q) begin
            if (cnt_q == CNT_MAX) begin
                state_d = sync;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        prev_d = state_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= {SYNC_STAGES{INIT_VALUE}};
            cnt_q   <= '0;
            state_q <= INIT_VALUE;
            prev_q  <= INIT_VALUE;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            prev_q  <= prev_d;
        end
    end

    // Both terms come from flops, so the pulses are glitch-free and
    // line up with the first cycle of the new out level.
    assign out  = state_q;
    assign rise = state_q & ~prev_q;
    assign fall = ~state_q & prev_q;

endmodule

// File: rtl/filter_bank.sv
// filter_bank: CHANNELS independent glitch filters with edge pulses.
// Ports:
//   clk, reset          - single clock, synchronous active-high reset
//   in[CHANNELS]        - raw asynchronous pad inputs
//   out[CHANNELS]       - filtered levels
//   rise/fall[CHANNELS] - one-cycle edge pulses aligned with out
//   evt_clr, evt_rise_pend, evt_fall_pend - sticky edge flags, only when
//     FILTER_BANK_EVENT_LATCH_EN is defined
module filter_bank
    import filter_pkg::*;
#(
    parameter int                  CHANNELS      = 8,
    parameter int                  FILTER_CYCLES = FILTER_DEFAULT_CYCLES,
    parameter int                  SYNC_STAGES   = FILTER_DEFAULT_SYNC,
    parameter logic [CHANNELS-1:0] INIT_VALUE    = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] in,
`ifdef FILTER_BANK_EVENT_LATCH_EN
    input  logic [CHANNELS-1:0] evt_clr,
    output logic [CHANNELS-1:0] evt_rise_pend,
    output logic [CHANNELS-1:0] evt_fall_pend,
`endif
    output logic [CHANNELS-1:0] out,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall
);

    if (CHANNELS < 1) begin : g_bad_channels
        $error("filter_bank: CHANNELS must be >= 1");
    end
    if (FILTER_CYCLES < 1) begin : g_bad_cycles
        $error("filter_bank: FILTER_CYCLES must be >= 1");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("filter_bank: SYNC_STAGES must be >= 2");
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        filter_channel #(
            .FILTER_CYCLES(FILTER_CYCLES),
            .SYNC_STAGES  (SYNC_STAGES),
            .INIT_VALUE   (INIT_VALUE[i])
        ) u_ch (
            .clk  (clk),
            .reset(reset),
            .din  (in[i]),
            .out  (out[i]),
            .rise (rise[i]),
            .fall (fall[i])
        );
    end

`ifdef FILTER_BANK_EVENT_LATCH_EN
    logic [CHANNELS-1:0] erp_q, erp_d;
    logic [CHANNELS-1:0] efp_q, efp_d;

    // Set is OR-ed in after the clear so an edge landing in the clear
    // cycle is still recorded.
    always_comb begin
        erp_d = (erp_q & ~evt_clr) | rise;
        efp_d = (efp_q & ~evt_clr) | fall;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            erp_q <= '0;
            efp_q <= '0;
        end else begin
            erp_q <= erp_d;
            efp_q <= efp_d;
        end
    end

    assign evt_rise_pend = erp_q;
    assign evt_fall_pend = efp_q;
`endif

endmodule

// File: tb/tb_filter_bank.sv
module tb_filter_bank;

    localparam int          N    = 8;
    localparam int          F    = 8;
    localparam int          S    = 2;
    localparam logic [N-1:0] INIT = 8'hA5;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] in, out, rise, fall;
`ifdef FILTER_BANK_EVENT_LATCH_EN
    logic [N-1:0] evt_clr, evt_rise_pend, evt_fall_pend;
    logic [N-1:0] m_erp, m_efp;
`endif

    always #5 clk = ~clk;

    filter_bank #(
        .CHANNELS(N), .FILTER_CYCLES(F), .SYNC_STAGES(S), .INIT_VALUE(INIT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in(in),
`ifdef FILTER_BANK_EVENT_LATCH_EN
        .evt_clr(evt_clr),
        .evt_rise_pend(evt_rise_pend),
        .evt_fall_pend(evt_fall_pend),
`endif
        .out(out),
        .rise(rise),
        .fall(fall)
    );

    int errs = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: in[] passes through an S-deep delay, then a
    // channel's level flips once the last F delayed samples all differ
    // from its current level. The window restarts on reset.
    logic [N-1:0] sq[$];
    logic [N-1:0] win[$];
    logic [N-1:0] m_out, m_prev;

    always @(posedge clk) begin
        logic [N-1:0] s, nxt;
        bit all_diff;
        if (reset) begin
            sq = {};
            for (int k = 0; k < S; k++) sq.push_back(INIT);
            win = {};
            m_out = INIT;
            m_prev = INIT;
`ifdef FILTER_BANK_EVENT_LATCH_EN
            m_erp = '0;
            m_efp = '0;
`endif
        end else begin
`ifdef FILTER_BANK_EVENT_LATCH_EN
            m_erp = (m_erp & ~evt_clr) | (m_out & ~m_prev);
            m_efp = (m_efp & ~evt_clr) | (~m_out & m_prev);
`endif
            s = sq.pop_front();
            sq.push_back(in);
            win.push_back(s);
            if (win.size() > F) void'(win.pop_front());
            nxt = m_out;
            if (win.size() == F) begin
                for (int i = 0; i < N; i++) begin
                    all_diff = 1'b1;
                    for (int k = 0; k < F; k++)
                        if (win[k][i] == m_out[i]) all_diff = 1'b0;
                    if (all_diff) nxt[i] = ~m_out[i];
                end
            end
            m_prev = m_out;
            m_out = nxt;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("out", 32'(out), 32'(m_out));
            chk("rise", 32'(rise), 32'(m_out & ~m_prev));
            chk("fall", 32'(fall), 32'(~m_out & m_prev));
`ifdef FILTER_BANK_EVENT_LATCH_EN
            chk("evt_rise_pend", 32'(evt_rise_pend), 32'(m_erp));
            chk("evt_fall_pend", 32'(evt_fall_pend), 32'(m_efp));
`endif
        end
    end

    // Counts negedges until out[ch]==v; n includes the capturing edge.
    task automatic wait_out(input int ch, input logic v, input int lim, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (out[ch] !== v && n < lim);
        if (out[ch] !== v) chk("wait_out_timeout", 32'(out[ch]), 32'(v));
    endtask

    initial begin
        int n, nr, nf, nh, anyp;
        in = INIT;
        reset = 1'b1;
`ifdef FILTER_BANK_EVENT_LATCH_EN
        evt_clr = '0;
`endif
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk_en = 1'b1;
        chk("reset_out", 32'(out), 32'h0000_00A5);

        // Quiet after reset: no pulses while in matches the init value.
        anyp = 0;
        repeat (20) begin
            @(negedge clk);
            anyp += int'(|(rise | fall));
        end
        chk("reset_quiet_pulses", 32'(anyp), 32'd0);
        chk("reset_hold_out", 32'(out), 32'h0000_00A5);

        // Clean step on channel 1 (init 0): 9 edges after capture.
        in[1] = 1'b1;
        wait_out(1, 1'b1, 40, n);
        chk("step_latency", 32'(n - 1), 32'd9);
        chk("step_rise", 32'(rise), 32'h0000_0002);
        @(negedge clk);
        chk("step_rise_one_cycle", 32'(rise[1]), 32'd0);

        // Glitch on channel 3: 7 clocks rejected, 8 clocks pass.
        for (int len = 7; len <= 8; len++) begin
            nr = 0; nf = 0; nh = 0;
            in[3] = 1'b1;
            for (int c = 0; c < 30; c++) begin
                @(negedge clk);
                nr += int'(rise[3]);
                nf += int'(fall[3]);
                nh += int'(out[3]);
                if (c == len - 1) in[3] = 1'b0;
            end
            if (len == 7) begin
                chk("glitch7_rise", 32'(nr), 32'd0);
                chk("glitch7_high", 32'(nh), 32'd0);
            end else begin
                chk("glitch8_rise", 32'(nr), 32'd1);
                chk("glitch8_fall", 32'(nf), 32'd1);
                chk("glitch8_width", 32'(nh), 32'd8);
            end
        end

        // Chatter on channel 5 (init 1): settle low, toggle every 3 clocks.
        in[5] = 1'b0;
        wait_out(5, 1'b0, 40, n);
        nr = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            nr += int'(rise[5]) + int'(fall[5]);
            if (c % 3 == 0) in[5] = ~in[5];
        end
        chk("chatter_no_pulse", 32'(nr), 32'd0);
        in[5] = 1'b0;
        @(negedge clk);
        in[5] = 1'b1;
        wait_out(5, 1'b1, 40, n);
        chk("chatter_latency", 32'(n - 1), 32'd9);
        nr = int'(rise[5]);
        repeat (20) begin
            @(negedge clk);
            nr += int'(rise[5]);
        end
        chk("chatter_one_rise", 32'(nr), 32'd1);

        // Reset at count 5 of a pending flip on channel 4 (init 0).
        in[4] = 1'b1;
        repeat (7) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midreset_out", 32'(out), 32'h0000_00A5);
        chk("midreset_pulses", 32'(rise | fall), 32'd0);
        wait_out(4, 1'b1, 40, n);
        chk("midreset_full_count", 32'(n), 32'd10);

`ifdef FILTER_BANK_EVENT_LATCH_EN
        // Clear coinciding with rise[2]: set wins, next clear empties.
        in[2] = 1'b0;
        repeat (20) @(negedge clk);
        in[2] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (rise[2] !== 1'b1 && n < 40);
        chk("evt_rise_seen", 32'(rise[2]), 32'd1);
        evt_clr[2] = 1'b1;
        @(negedge clk);
        chk("evt_set_wins", 32'(evt_rise_pend[2]), 32'd1);
        @(negedge clk);
        chk("evt_cleared", 32'(evt_rise_pend[2]), 32'd0);
        evt_clr[2] = 1'b0;
`endif

        // Randomized traffic; mean run length ~12 straddles the window.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 11) == 0) in[i] = ~in[i];
`ifdef FILTER_BANK_EVENT_LATCH_EN
            for (int i = 0; i < N; i++)
                evt_clr[i] = ($urandom_range(0, 3) == 0);
`endif
            reset = ($urandom_range(0, 499) == 0);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
